// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the FSM encoding, the $zero index and default widths.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam int REG_ZERO = 0;

    typedef enum logic [2:0] {
        EMPTY,
        H0,
        H1,
        H01_O0,
        H01_O1
    } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two valid/ready request ports, flush, and the
// register-file write port plus conflict counter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W_DEF,
    parameter int CNT_W  = regfile_wb_arbiter_pkg::CNT_W_DEF
);
    logic              flush;
    logic              p0_valid;
    logic              p0_ready;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p1_valid;
    logic              p1_ready;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  flush,
        input  p0_valid, p0_addr, p0_data,
        input  p1_valid, p1_addr, p1_data,
        output p0_ready, p1_ready,
        output rf_we, rf_waddr, rf_wdata,
        output conflict_cnt
    );

    modport master (
        output flush,
        output p0_valid, p0_addr, p0_data,
        output p1_valid, p1_addr, p1_data,
        input  p0_ready, p1_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  conflict_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_hold_buf.sv
// One-entry write-back holding buffer (valid/addr/data).
// Load has priority over clear so drain and refill share a cycle.
module wb_hold_buf #(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Capture a new entry, or drop the current one when cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (port 0) and load (port 1) write-backs onto the single
// register-file write port, oldest first. Option: REGFILE_WB_PENDING_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_wb_arbiter_if.slave        bus
`ifdef REGFILE_WB_PENDING_EN
    ,
    output logic [(2**ADDR_W)-1:0]     pending_mask
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    wb_state_e state;
    wb_state_e state_nxt;

    logic              full0, full1;
    logic              sel0, sel1;
    logic              rdy0, rdy1;
    logic              load0, load1;
    logic              clr0, clr1;
    logic              v0, v1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic [CNT_W-1:0]  cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush empties; otherwise track occupancy and age.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY, H0, H1: begin
                    if (load0 && load1) state_nxt = H01_O0;
                    else if (load0)     state_nxt = H0;
                    else if (load1)     state_nxt = H1;
                    else                state_nxt = EMPTY;
                end
                H01_O0:  state_nxt = load0 ? H01_O1 : H1;
                H01_O1:  state_nxt = load1 ? H01_O0 : H0;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Decode occupancy and which buffer owns the write port.
    always_comb begin
        full0 = 1'b0;
        full1 = 1'b0;
        sel0  = 1'b0;
        sel1  = 1'b0;
        unique case (state)
            H0: begin
                full0 = 1'b1;
                sel0  = 1'b1;
            end
            H1: begin
                full1 = 1'b1;
                sel1  = 1'b1;
            end
            H01_O0: begin
                full0 = 1'b1;
                full1 = 1'b1;
                sel0  = 1'b1;
            end
            H01_O1: begin
                full0 = 1'b1;
                full1 = 1'b1;
                sel1  = 1'b1;
            end
            default: ;
        endcase
    end

    // Ready depends only on state, flush and reset, never on valid.
    always_comb begin
        rdy0  = rst_n && !bus.flush && (!full0 || sel0);
        rdy1  = rst_n && !bus.flush && (!full1 || sel1);
        load0 = bus.p0_valid && rdy0 && (bus.p0_addr != ZERO_IDX);
        load1 = bus.p1_valid && rdy1 && (bus.p1_addr != ZERO_IDX);
        clr0  = sel0 || bus.flush;
        clr1  = sel1 || bus.flush;
        bus.p0_ready = rdy0;
        bus.p1_ready = rdy1;
    end

    // Drive the write port from the selected buffer, zero when idle.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (sel0 && v0) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = a0;
            bus.rf_wdata = d0;
        end else if (sel1 && v1) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = a1;
            bus.rf_wdata = d1;
        end
    end

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .clear     (clr0),
        .load_addr (bus.p0_addr),
        .load_data (bus.p0_data),
        .valid     (v0),
        .addr      (a0),
        .data      (d0)
    );

    wb_hold_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .clear     (clr1),
        .load_addr (bus.p1_addr),
        .load_data (bus.p1_data),
        .valid     (v1),
        .addr      (a1),
        .data      (d1)
    );

    // Count cycles spent with one entry queued behind the other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == H01_O0 || state == H01_O1) && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.conflict_cnt = cnt;

`ifdef REGFILE_WB_PENDING_EN
    // Registers with a write still in flight, for RAW stall decode.
    always_comb begin
        pending_mask = '0;
        if (full0) pending_mask[a0] = 1'b1;
        if (full1) pending_mask[a1] = 1'b1;
        pending_mask[REG_ZERO] = 1'b0;
    end
`endif

endmodule
